// File: rtl/sm_result_if.sv
// Handshake bundle between the sign-magnitude adder, the result stage and its consumer.
// The "slave" view belongs to the result stage; the "master" view drives it
// (adder on the input side, consumer on the output side).
interface sm_result_if;
    // Upstream: adder result, 9-bit sign-magnitude ([8] sign, [7:0] magnitude)
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_sum;
    // Downstream: normalised 8-bit sign-magnitude head entry
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    modport slave (
        input  in_valid,
        input  in_sum,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_sum,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_ovf
    );
endinterface

// File: rtl/sm_result_stage.sv
// Registered output stage behind the 8-bit sign-magnitude adder.
// Each accepted 9-bit result is saturated to 7-bit magnitude, negative zero is
// folded to +0, and the entry {ovf, sign, magnitude} is queued in a small FIFO.
// A saturating counter tracks how many accepted results had to be clipped.
module sm_result_stage #(
    parameter int DEPTH = 2,   // FIFO entries, power of two, >= 2
    parameter int CNT_W = 8    // overflow counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_result_if.slave       bus,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // while still using every storage slot.
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       mem_q [DEPTH];

    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [7:0]       in_mag;
    logic             in_sgn;
    logic             norm_ovf;
    logic             norm_sgn;
    logic [6:0]       norm_mag;
    logic [8:0]       norm_entry;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Occupancy flags come only from registered pointers, so in_ready and
    // out_valid never depend combinationally on in_valid or out_ready.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    // Head entry straight from storage; reset clears storage so the outputs
    // read as zero while the FIFO is empty after reset.
    assign {bus.out_ovf, bus.out_data} = mem_q[rd_idx];

    assign ovf_count = cnt_q;

    // Normalise the incoming 9-bit result to 8-bit sign-magnitude with saturation.
    always_comb begin
        in_mag     = bus.in_sum[7:0];
        in_sgn     = bus.in_sum[8];
        norm_ovf   = 1'b0;
        norm_mag   = in_mag[6:0];
        norm_sgn   = in_sgn;
        if (in_mag > 8'd127) begin
            norm_ovf = 1'b1;
            norm_mag = 7'h7F;
        end
        // Negative zero is not a distinct value downstream; store it as +0.
        if (in_mag == 8'd0) begin
            norm_sgn = 1'b0;
        end
        norm_entry = {norm_ovf, norm_sgn, norm_mag};
    end

    // Next-state for pointers and the overflow counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Clear wins over a same-cycle increment; the count sticks at all-ones.
        if (clr_count) begin
            cnt_d = '0;
        end else if (push && norm_ovf && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage: cleared on reset, written at the tail on each accepted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_idx] <= norm_entry;
        end
    end

endmodule
